// File: rtl/apb_req_bridge_if.sv
// Bundles the core-side request/grant/rvalid port and the APB3 master bus of apb_req_bridge.
// The bridge takes the slave modport; the core plus APB peripheral environment takes master.
interface apb_req_bridge_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic                      req_i;
    logic                      gnt_o;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic                      we_i;
    logic [APB_DATA_WIDTH-1:0] wdata_i;
    logic                      rvalid_o;
    logic [APB_DATA_WIDTH-1:0] rdata_o;
    logic                      err_o;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, prdata, pready, pslverr,
        output gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, prdata, pready, pslverr,
        input  gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_req_bridge.sv
// Core request/grant/rvalid port to APB3 master bridge with address-window rejection
// and a pready watchdog that turns a hung slave into an error response.
module apb_req_bridge #(
    parameter int unsigned               APB_ADDR_WIDTH = 32,
    parameter int unsigned               APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_START      = APB_ADDR_WIDTH'(32'h1A10_0000),
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_END        = APB_ADDR_WIDTH'(32'h1A11_7FFF),
    parameter int unsigned               TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    apb_req_bridge_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Watchdog value on the last ACCESS cycle allowed before the forced error.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wd;

    function automatic logic in_window(input logic [APB_ADDR_WIDTH-1:0] a);
        return (a >= WIN_START) && (a <= WIN_END);
    endfunction

    function automatic logic wd_expired(input logic [15:0] cnt);
        return cnt == WD_LAST;
    endfunction

    assign bus.gnt_o = bus.req_i && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wd           <= '0;
            bus.psel     <= 1'b0;
            bus.penable  <= 1'b0;
            bus.pwrite   <= 1'b0;
            bus.paddr    <= '0;
            bus.pwdata   <= '0;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.rvalid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        bus.paddr  <= bus.addr_i;
                        bus.pwrite <= bus.we_i;
                        bus.pwdata <= bus.wdata_i;
                        if (in_window(bus.addr_i)) begin
                            state    <= SETUP;
                            wd       <= '0;
                            bus.psel <= 1'b1;
                        end else begin
                            // Rejected without touching the APB bus.
                            state        <= RESP;
                            bus.rvalid_o <= 1'b1;
                            bus.err_o    <= 1'b1;
                            bus.rdata_o  <= '0;
                        end
                    end
                end

                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end

                ACCESS: begin
                    wd <= wd + 16'd1;
                    if (bus.pready) begin
                        state        <= RESP;
                        bus.psel     <= 1'b0;
                        bus.penable  <= 1'b0;
                        bus.rvalid_o <= 1'b1;
                        bus.err_o    <= bus.pslverr;
                        bus.rdata_o  <= bus.pwrite ? '0 : bus.prdata;
                    end else if (wd_expired(wd)) begin
                        // Abandon the slave; dropping psel ends its transfer.
                        state        <= RESP;
                        bus.psel     <= 1'b0;
                        bus.penable  <= 1'b0;
                        bus.rvalid_o <= 1'b1;
                        bus.err_o    <= 1'b1;
                        bus.rdata_o  <= '0;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge: stimulus pushes expected responses, a monitor pops
// and compares them (data, error, arrival cycle) whenever rvalid_o is seen.
module tb_apb_req_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_req_bridge_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_req_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .WIN_START     (32'h1A10_0000),
        .WIN_END       (32'h1A11_7FFF),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          wait_n      = 0;
    int          acc_cnt     = 0;
    int          acc_cycles  = 0;
    logic [31:0] rd_val      = '0;
    logic [31:0] err_addr    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // APB slave model: pready after wait_n wait states, pslverr for err_addr.
    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            acc_cycles++;
            if (acc_cnt == wait_n) begin
                bus.pready  = 1'b1;
                bus.prdata  = rd_val;
                bus.pslverr = (bus.paddr == err_addr);
            end else begin
                bus.pready  = 1'b0;
                bus.prdata  = '0;
                bus.pslverr = 1'b0;
            end
            acc_cnt++;
        end else begin
            acc_cnt     = 0;
            bus.pready  = 1'b0;
            bus.prdata  = '0;
            bus.pslverr = 1'b0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && bus.rvalid_o) begin
            check("rsp_psel_penable_low", 32'({bus.psel, bus.penable}), 32'd0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rdata_o, e.rdata);
                check("rsp_err", 32'(bus.err_o), 32'(e.err));
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input int lat,
                         input bit track, output int g, output int waited);
        rsp_t e;
        bus.req_i   = 1'b1;
        bus.addr_i  = a;
        bus.we_i    = w;
        bus.wdata_i = d;
        waited = 0;
        g      = -1;
        while (g < 0) begin
            @(negedge clk);
            if (bus.gnt_o) begin
                g = cyc;
            end else begin
                waited++;
                if (waited > 20) begin
                    check("grant_timeout", 32'd1, 32'd0);
                    break;
                end
            end
        end
        if (g >= 0 && track) begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = g + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] win_a [5];
    bit          win_in[5];

    initial begin
        int g, g2, wt;
        bus.req_i   = 1'b0;
        bus.addr_i  = '0;
        bus.we_i    = 1'b0;
        bus.wdata_i = '0;
        win_a  = '{32'h1A10_0000, 32'h1A11_7FFF, 32'h1A11_8000, 32'h1A12_0000, 32'h1A0F_FFFF};
        win_in = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_psel_penable_pwrite", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
        check("rst_paddr", bus.paddr, 32'd0);
        check("rst_pwdata", bus.pwdata, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        rst = 1'b0;

        // Zero-wait write: psel one cycle after grant, penable one later.
        wait_n = 0;
        rd_val = 32'h7777_7777;
        issue(32'h1A10_1000, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b1, g, wt);
        @(negedge clk);
        check("wr_setup_psel_penable", 32'({bus.psel, bus.penable}), 32'd2);
        check("wr_setup_pwrite", 32'(bus.pwrite), 32'd1);
        check("wr_setup_paddr", bus.paddr, 32'h1A10_1000);
        check("wr_setup_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_access_psel_penable", 32'({bus.psel, bus.penable}), 32'd3);
        check("wr_access_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        wait_done("wr");

        // Read with four wait states.
        wait_n = 4;
        rd_val = 32'h1234_5678;
        issue(32'h1A10_3004, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 7, 1'b1, g, wt);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("rd_wait_paddr", bus.paddr, 32'h1A10_3004);
            check("rd_wait_penable", 32'(bus.penable), 32'd1);
        end
        wait_done("rd_wait");

        // Slave error, then back-to-back request granted right after RESP.
        wait_n   = 0;
        rd_val   = 32'hCAFE_0001;
        err_addr = 32'h1A10_7000;
        issue(32'h1A10_7000, 1'b0, 32'h0, 32'hCAFE_0001, 1'b1, 3, 1'b1, g, wt);
        issue(32'h1A11_7FFF, 1'b1, 32'h0000_55AA, 32'h0, 1'b0, 3, 1'b1, g2, wt);
        check("b2b_grant_spacing", g2 - g, 32'd4);
        wait_done("slverr_b2b");
        err_addr = '0;

        // Window edges and outside addresses.
        for (int i = 0; i < 5; i++) begin
            rd_val = ~win_a[i];
            issue(win_a[i], 1'b0, 32'h0, win_in[i] ? ~win_a[i] : 32'h0, !win_in[i],
                  win_in[i] ? 3 : 1, 1'b1, g, wt);
            @(negedge clk);
            if (!win_in[i]) check("win_reject_psel", 32'(bus.psel), 32'd0);
            wait_done("win");
        end

        // Hung slave: watchdog forces an error after 8 ACCESS cycles.
        wait_n     = 1000;
        acc_cycles = 0;
        issue(32'h1A10_2000, 1'b0, 32'h0, 32'h0, 1'b1, 10, 1'b1, g, wt);
        wait_done("timeout");
        check("timeout_access_cycles", acc_cycles, 32'd8);

        wait_n = 0;
        rd_val = 32'h0BAD_F00D;
        issue(32'h1A10_2004, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b1, g, wt);
        wait_done("after_timeout");

        // pready on the expiry cycle: normal response.
        wait_n     = 7;
        rd_val     = 32'h600D_CAFE;
        acc_cycles = 0;
        issue(32'h1A10_2008, 1'b0, 32'h0, 32'h600D_CAFE, 1'b0, 10, 1'b1, g, wt);
        wait_done("pready_wins");
        check("pready_wins_access_cycles", acc_cycles, 32'd8);

        // Reset during ACCESS drops the transfer without a response.
        wait_n = 1000;
        issue(32'h1A10_4000, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, g, wt);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_in_access", 32'({bus.psel, bus.penable}), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_psel_penable", 32'({bus.psel, bus.penable}), 32'd0);
        check("rst_mid_rvalid", 32'(bus.rvalid_o), 32'd0);
        wait_n = 0;
        rd_val = 32'h1357_9BDF;
        issue(32'h1A10_4004, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 3, 1'b1, g, wt);
        check("rst_regrant_wait", wt, 32'd0);
        wait_done("after_rst");

        repeat (5) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
